// File: rtl/piradspi_peripheral.sv
// rtl/piradspi_peripheral.sv - PiRadSPI SPI peripheral (slave), oversampled in the clk domain
// Optional stats counters: define PIRADSPI_PERIPH_STATS_EN.
module piradspi_peripheral #(
    parameter int               WIDTH     = 32,
    parameter bit               CPOL      = 1'b0,
    parameter bit               CPHA      = 1'b0,
    parameter logic [WIDTH-1:0] IDLE_WORD = '1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             sclk,
    input  logic             csn,
    input  logic             mosi,
    output logic             miso,
    output logic             miso_oe,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             tx_underrun,
    output logic             frame_abort,
    output logic             busy
`ifdef PIRADSPI_PERIPH_STATS_EN
    ,
    input  logic             stats_clr,
    output logic [47:0]      stats
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       sclk_sync_q, sclk_sync_d, csn_sync_q, csn_sync_d, mosi_sync_q, mosi_sync_d;
    logic             sclk_prev_q, sclk_prev_d, csn_prev_q, csn_prev_d;
    logic [1:0]       init_q, init_d;
    logic             armed_q, armed_d;
    logic [WIDTH-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic [WIDTH-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             miso_q, miso_d, miso_oe_q, miso_oe_d;
    logic             rx_valid_q, rx_valid_d, tx_underrun_q, tx_underrun_d;
    logic             frame_abort_q, frame_abort_d;

    logic             sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
    logic             csn_fall, csn_rise, load;
    logic [WIDTH-1:0] load_word;

    assign sclk_rise   = sclk_sync_q[1] & ~sclk_prev_q;
    assign sclk_fall   = ~sclk_sync_q[1] & sclk_prev_q;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign csn_fall    = ~csn_sync_q[1] & csn_prev_q;
    assign csn_rise    = csn_sync_q[1] & ~csn_prev_q;
    assign load_word   = hold_full_q ? hold_q : IDLE_WORD;

    always_comb begin
        state_d       = state_q;
        sclk_sync_d   = {sclk_sync_q[0], sclk};
        csn_sync_d    = {csn_sync_q[0], csn};
        mosi_sync_d   = {mosi_sync_q[0], mosi};
        sclk_prev_d   = sclk_sync_q[1];
        csn_prev_d    = csn_sync_q[1];
        // The csn chain holds its reset value for two cycles; only arm once it shows a real high.
        init_d        = {init_q[0], 1'b1};
        armed_d       = armed_q | (init_q[1] & csn_sync_q[1]);
        tx_shift_d    = tx_shift_q;
        rx_shift_d    = rx_shift_q;
        hold_d        = hold_q;
        hold_full_d   = hold_full_q;
        rx_data_d     = rx_data_q;
        bit_cnt_d     = bit_cnt_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        rx_valid_d    = 1'b0;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        load          = 1'b0;

        case (state_q)
            IDLE: begin
                if (csn_fall && armed_q) begin
                    state_d   = ACTIVE;
                    load      = 1'b1;
                    bit_cnt_d = '0;
                    miso_oe_d = 1'b1;
                end
            end
            ACTIVE: begin
                if (csn_rise) begin
                    state_d   = IDLE;
                    miso_oe_d = 1'b0;
                    miso_d    = 1'b0;
                    bit_cnt_d = '0;
                    if (bit_cnt_q == CW'(WIDTH)) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                    end else if (bit_cnt_q != '0) begin
                        frame_abort_d = 1'b1;
                    end
                end else if (bit_cnt_q == CW'(WIDTH)) begin
                    rx_data_d  = rx_shift_q;
                    rx_valid_d = 1'b1;
                    bit_cnt_d  = '0;
                    load       = 1'b1;
                end else if (sample_edge) begin
                    rx_shift_d = {rx_shift_q[WIDTH-2:0], mosi_sync_q[1]};
                    bit_cnt_d  = bit_cnt_q + CW'(1);
                end else if (shift_edge && (CPHA || bit_cnt_q != '0)) begin
                    miso_d     = tx_shift_q[WIDTH-1];
                    tx_shift_d = {tx_shift_q[WIDTH-2:0], 1'b0};
                end
            end
            default: state_d = IDLE;
        endcase

        // CPHA=0 must present the MSB before the first sample edge, so it leaves the shifter at load.
        if (load) begin
            if (CPHA) begin
                tx_shift_d = load_word;
            end else begin
                tx_shift_d = {load_word[WIDTH-2:0], 1'b0};
                miso_d     = load_word[WIDTH-1];
            end
            tx_underrun_d = ~hold_full_q;
            hold_full_d   = 1'b0;
        end
        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            sclk_sync_q   <= {CPOL, CPOL};
            csn_sync_q    <= 2'b11;
            mosi_sync_q   <= 2'b00;
            sclk_prev_q   <= CPOL;
            csn_prev_q    <= 1'b1;
            init_q        <= 2'b00;
            armed_q       <= 1'b0;
            tx_shift_q    <= '0;
            rx_shift_q    <= '0;
            hold_q        <= '0;
            hold_full_q   <= 1'b0;
            rx_data_q     <= '0;
            bit_cnt_q     <= '0;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            rx_valid_q    <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_sync_q   <= sclk_sync_d;
            csn_sync_q    <= csn_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sclk_prev_q   <= sclk_prev_d;
            csn_prev_q    <= csn_prev_d;
            init_q        <= init_d;
            armed_q       <= armed_d;
            tx_shift_q    <= tx_shift_d;
            rx_shift_q    <= rx_shift_d;
            hold_q        <= hold_d;
            hold_full_q   <= hold_full_d;
            rx_data_q     <= rx_data_d;
            bit_cnt_q     <= bit_cnt_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            rx_valid_q    <= rx_valid_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
        end
    end

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;
    assign busy        = (state_q == ACTIVE);

`ifdef PIRADSPI_PERIPH_STATS_EN
    logic [15:0] words_q, words_d, unders_q, unders_d, aborts_q, aborts_d;

    always_comb begin
        words_d  = words_q;
        unders_d = unders_q;
        aborts_d = aborts_q;
        if (stats_clr) begin
            words_d  = '0;
            unders_d = '0;
            aborts_d = '0;
        end else begin
            if (rx_valid_q && words_q != 16'hFFFF)     words_d  = words_q + 16'd1;
            if (tx_underrun_q && unders_q != 16'hFFFF) unders_d = unders_q + 16'd1;
            if (frame_abort_q && aborts_q != 16'hFFFF) aborts_d = aborts_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            words_q  <= '0;
            unders_q <= '0;
            aborts_q <= '0;
        end else begin
            words_q  <= words_d;
            unders_q <= unders_d;
            aborts_q <= aborts_d;
        end
    end

    assign stats = {aborts_q, unders_q, words_q};
`endif

endmodule

// File: tb/tb_piradspi_peripheral.sv
// tb/tb_piradspi_peripheral.sv - bench for piradspi_peripheral (mode 0 and mode 3 instances)
module tb_piradspi_peripheral;

    localparam int W = 32;
    localparam int H = 6;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   sclk_v, csn_v, mosi_v, tx_valid_v;
    logic [W-1:0] tx_data_v [2];
    logic         miso0, miso1, oe0, oe1, txr0, txr1, rxv0, rxv1;
    logic         und0, und1, abt0, abt1, busy0, busy1;
    logic [W-1:0] rxd0, rxd1;
`ifdef PIRADSPI_PERIPH_STATS_EN
    logic [47:0]  st0, st1;
`endif

    piradspi_peripheral #(.WIDTH(W), .CPOL(1'b0), .CPHA(1'b0)) u_mode0 (
        .clk(clk), .rstn(rstn), .sclk(sclk_v[0]), .csn(csn_v[0]), .mosi(mosi_v[0]),
        .miso(miso0), .miso_oe(oe0), .tx_data(tx_data_v[0]), .tx_valid(tx_valid_v[0]),
        .tx_ready(txr0), .rx_data(rxd0), .rx_valid(rxv0), .tx_underrun(und0),
        .frame_abort(abt0), .busy(busy0)
`ifdef PIRADSPI_PERIPH_STATS_EN
        , .stats_clr(1'b0), .stats(st0)
`endif
    );

    piradspi_peripheral #(.WIDTH(W), .CPOL(1'b1), .CPHA(1'b1)) u_mode3 (
        .clk(clk), .rstn(rstn), .sclk(sclk_v[1]), .csn(csn_v[1]), .mosi(mosi_v[1]),
        .miso(miso1), .miso_oe(oe1), .tx_data(tx_data_v[1]), .tx_valid(tx_valid_v[1]),
        .tx_ready(txr1), .rx_data(rxd1), .rx_valid(rxv1), .tx_underrun(und1),
        .frame_abort(abt1), .busy(busy1)
`ifdef PIRADSPI_PERIPH_STATS_EN
        , .stats_clr(1'b0), .stats(st1)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    int rxc0 = 0, rxc1 = 0, unc0 = 0, unc1 = 0, abc0 = 0, abc1 = 0;
    logic [W-1:0] rxlog0 [64];
    logic [W-1:0] rxlog1 [64];

    always @(negedge clk) begin
        if (rxv0) begin rxlog0[rxc0 % 64] = rxd0; rxc0++; end
        if (rxv1) begin rxlog1[rxc1 % 64] = rxd1; rxc1++; end
        if (und0) unc0++;
        if (und1) unc1++;
        if (abt0) abc0++;
        if (abt1) abc1++;
    end

    function automatic int rx_cnt(input int m);
        return (m == 1) ? rxc1 : rxc0;
    endfunction
    function automatic int und_cnt(input int m);
        return (m == 1) ? unc1 : unc0;
    endfunction
    function automatic int abt_cnt(input int m);
        return (m == 1) ? abc1 : abc0;
    endfunction
    function automatic logic [W-1:0] rx_word(input int m, input int idx);
        return (m == 1) ? rxlog1[idx % 64] : rxlog0[idx % 64];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [W-1:0] mtx [4];
    logic [W-1:0] mrx [4];
    int und_start;

    // Bus-level SPI master: mode 0 when m=0, mode 3 (CPOL=1, CPHA=1) when m=1.
    task automatic xfer(input int m, input int nbits, input bit keep_cs);
        logic cp;
        int w, b;
        cp = (m == 1);
        for (int k = 0; k < 4; k++) mrx[k] = '0;
        @(posedge clk);
        sclk_v[m] = cp;
        csn_v[m]  = 1'b0;
        repeat (H) @(posedge clk);
        und_start = und_cnt(m);
        for (int i = 0; i < nbits; i++) begin
            w = i / W;
            b = W - 1 - (i % W);
            if (!cp) begin
                mosi_v[m] = mtx[w][b];
                repeat (H) @(posedge clk);
                sclk_v[m] = 1'b1;
                mrx[w][b] = miso0;
                repeat (H) @(posedge clk);
                sclk_v[m] = 1'b0;
            end else begin
                sclk_v[m] = 1'b0;
                mosi_v[m] = mtx[w][b];
                repeat (H) @(posedge clk);
                sclk_v[m] = 1'b1;
                mrx[w][b] = miso1;
                repeat (H) @(posedge clk);
            end
        end
        if (!keep_cs) begin
            repeat (H) @(posedge clk);
            csn_v[m] = 1'b1;
            repeat (3 * H) @(posedge clk);
        end
    endtask

    task automatic hwrite(input int m, input logic [W-1:0] d);
        @(negedge clk);
        chk($sformatf("tx_ready%0d_before_write", m), (m == 1) ? txr1 : txr0, 1);
        tx_data_v[m]  = d;
        tx_valid_v[m] = 1'b1;
        @(negedge clk);
        tx_valid_v[m] = 1'b0;
    endtask

    // Reference: one load at frame start plus one at every completed word; only the
    // first load can find the preloaded word, every other load underruns.
    task automatic run_frame(input string tag, input int m, input int n, input int e,
                             input bit p, input logic [W-1:0] pv);
        int r0, u0, a0;
        logic [W-1:0] exp_tx;
        if (p) hwrite(m, pv);
        r0 = rx_cnt(m);
        u0 = und_cnt(m);
        a0 = abt_cnt(m);
        xfer(m, n * W + e, 1'b0);
        chk({tag, "_rx_count"}, rx_cnt(m) - r0, n);
        for (int k = 0; k < n; k++) begin
            exp_tx = (k == 0 && p) ? pv : '1;
            chk($sformatf("%s_rx_word%0d", tag, k), rx_word(m, r0 + k), mtx[k]);
            chk($sformatf("%s_miso_word%0d", tag, k), mrx[k], exp_tx);
        end
        chk({tag, "_underrun_at_start"}, und_start - u0, int'(!p));
        chk({tag, "_underrun_total"}, und_cnt(m) - u0, 1 + n - int'(p));
        chk({tag, "_abort_count"}, abt_cnt(m) - a0, int'(e > 0));
        chk({tag, "_tx_ready_after"}, (m == 1) ? txr1 : txr0, 1);
    endtask

    initial begin
        int r0, u0, a0;
        int m, n, e;
        bit p;
        logic [W-1:0] pv;

        sclk_v = 2'b10;
        csn_v = 2'b11;
        mosi_v = 2'b00;
        tx_valid_v = 2'b00;
        tx_data_v[0] = '0;
        tx_data_v[1] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_miso0", {miso0, oe0, txr0, rxv0, und0, abt0, busy0}, 7'b0010000);
        chk("reset_miso1", {miso1, oe1, txr1, rxv1, und1, abt1, busy1}, 7'b0010000);
        chk("reset_rx_data", {rxd1, rxd0}, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (10) @(posedge clk);

        mtx[0] = 32'hA5A6A7A8;
        run_frame("mode0_single", 0, 1, 0, 1'b1, 32'h01020304);

        hwrite(0, 32'h11223344);
        mtx[0] = 32'hA1A2A3A4;
        mtx[1] = 32'hA5A6A7A8;
        r0 = rx_cnt(0);
        u0 = und_cnt(0);
        fork
            xfer(0, 2 * W, 1'b0);
            begin
                repeat (40) @(negedge clk);
                hwrite(0, 32'h55667788);
            end
        join
        chk("two_word_rx_count", rx_cnt(0) - r0, 2);
        chk("two_word_rx0", rx_word(0, r0), 32'hA1A2A3A4);
        chk("two_word_rx1", rx_word(0, r0 + 1), 32'hA5A6A7A8);
        chk("two_word_miso0", mrx[0], 32'h11223344);
        chk("two_word_miso1", mrx[1], 32'h55667788);
        chk("two_word_underrun_at_start", und_start - u0, 0);
        chk("two_word_underrun_total", und_cnt(0) - u0, 1);

        mtx[0] = $urandom;
        run_frame("underrun", 0, 1, 0, 1'b0, '0);

        mtx[0] = $urandom;
        run_frame("abort12", 0, 0, 12, 1'b0, '0);
        mtx[0] = 32'h0F0F0F0F;
        run_frame("after_abort", 0, 1, 0, 1'b1, $urandom);

        mtx[0] = 32'hDEADBEEF;
        run_frame("mode3", 1, 1, 0, 1'b1, 32'hCAFEF00D);

        for (int it = 0; it < 8; it++) begin
            m  = $urandom_range(0, 1);
            n  = $urandom_range(1, 3);
            e  = ($urandom_range(0, 1) == 1) ? $urandom_range(1, W - 1) : 0;
            p  = $urandom_range(0, 1);
            pv = $urandom;
            for (int k = 0; k < 4; k++) mtx[k] = $urandom;
            run_frame($sformatf("rand%0d_m%0d", it, m), m, n, e, p, pv);
        end

        hwrite(0, 32'h13579BDF);
        mtx[0] = $urandom;
        fork
            xfer(0, 20, 1'b1);
            begin
                repeat (40) @(negedge clk);
                hwrite(0, 32'h2468ACE0);
            end
        join
        chk("pre_reset_hold_full", txr0, 0);
        chk("pre_reset_busy", busy0, 1);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midreset_outputs", {miso0, oe0, txr0, rxv0, und0, abt0, busy0}, 7'b0010000);
        chk("midreset_rx_data", rxd0, 32'd0);
        r0 = rx_cnt(0);
        u0 = und_cnt(0);
        a0 = abt_cnt(0);
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            repeat (H) @(posedge clk);
            sclk_v[0] = ~sclk_v[0];
        end
        repeat (H) @(posedge clk);
        #1;
        chk("csn_low_release_busy", busy0, 0);
        chk("csn_low_release_oe", oe0, 0);
        chk("csn_low_release_strobes", (rx_cnt(0) - r0) + (und_cnt(0) - u0) + (abt_cnt(0) - a0), 0);
        csn_v[0] = 1'b1;
        repeat (3 * H) @(posedge clk);
        mtx[0] = $urandom;
        run_frame("post_reset", 0, 1, 0, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
